// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: sequences 16-bit CALL/RET return addresses through an 8-bit hardware stack.
// Optional stack-flag consistency check is built when CALLSTK_CHECK_EN is defined.
module call_stack_ctrl #(
    parameter int unsigned STACK_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] ret_addr_in,
    output logic [15:0] ret_addr_out,
    output logic        busy,
    output logic        done,
    output logic        ovf_err,
    output logic        unf_err,
    output logic [5:0]  depth,
    output logic        stk_push,
    output logic        stk_pop,
    output logic [7:0]  stk_data_in,
    input  logic [7:0]  stk_data_out,
    input  logic        stk_empty,
    input  logic        stk_full,
    output logic        sync_err
);

    // Two entries are held back: a completely full stack wraps its pointer.
    localparam int unsigned USABLE = STACK_DEPTH - 2;

    typedef enum logic [2:0] {
        StIdle,
        StPushLo,
        StPushHi,
        StPopHi,
        StPopLo,
        StCapLo
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] ret_addr_q, ret_addr_d;
    logic [5:0]  depth_q, depth_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        room;

    assign room = (32'(depth_q) + 32'd2) <= USABLE;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ret_addr_d  = ret_addr_q;
        depth_d     = depth_q;
        done_d      = 1'b0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (call_req) begin
                    if (room) begin
                        addr_d  = ret_addr_in;
                        state_d = StPushLo;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (ret_req) begin
                    if (depth_q >= 6'd2) begin
                        state_d = StPopHi;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end
            StPushLo: begin
                stk_push    = 1'b1;
                stk_data_in = addr_q[7:0];
                state_d     = StPushHi;
            end
            StPushHi: begin
                stk_push    = 1'b1;
                stk_data_in = addr_q[15:8];
                depth_d     = depth_q + 6'd2;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            StPopHi: begin
                stk_pop = 1'b1;
                state_d = StPopLo;
            end
            StPopLo: begin
                // data_out now holds the high byte popped on the previous edge
                stk_pop        = 1'b1;
                addr_d[15:8]   = stk_data_out;
                state_d        = StCapLo;
            end
            StCapLo: begin
                ret_addr_d = {addr_q[15:8], stk_data_out};
                depth_d    = depth_q - 6'd2;
                done_d     = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= 16'h0000;
            ret_addr_q <= 16'h0000;
            depth_q    <= 6'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ret_addr_q <= ret_addr_d;
            depth_q    <= depth_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign ret_addr_out = ret_addr_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;
    assign depth        = depth_q;

`ifdef CALLSTK_CHECK_EN
    logic prev_idle_q;
    logic sync_err_q;

    // Stack flags lag by one cycle, so only compare after two consecutive idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_idle_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            prev_idle_q <= (state_q == StIdle);
            if ((state_q == StIdle) && prev_idle_q &&
                ((stk_empty != (depth_q == 6'd0)) || stk_full)) begin
                sync_err_q <= 1'b1;
            end
        end
    end

    assign sync_err = sync_err_q;
`else
    logic unused_flags;
    assign unused_flags = stk_empty ^ stk_full;
    assign sync_err     = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: behavioural byte stack plus table-driven CALL/RET ops.
module tb_call_stack_ctrl;

`ifdef CALLSTK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        call_req, ret_req;
    logic [15:0] ret_addr_in, ret_addr_out;
    logic        busy, done, ovf_err, unf_err;
    logic [5:0]  depth;
    logic        stk_push, stk_pop;
    logic [7:0]  stk_data_in, stk_data_out;
    logic        stk_empty, stk_full, sync_err;

    call_stack_ctrl #(.STACK_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .ret_addr_in(ret_addr_in), .ret_addr_out(ret_addr_out), .busy(busy),
        .done(done), .ovf_err(ovf_err), .unf_err(unf_err), .depth(depth),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Behavioural 32-entry byte stack with registered data_out and lagging flags.
    logic [7:0] mem [0:31];
    int         count;
    logic [7:0] dout_q;
    logic       empty_q, full_q;
    logic       force_nonempty = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            count   <= 0;
            dout_q  <= 8'h00;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            empty_q <= (count == 0);
            full_q  <= (count == 32);
            if (stk_push && count < 32) begin
                mem[count] <= stk_data_in;
                count      <= count + 1;
            end else if (stk_pop && count > 0) begin
                dout_q <= mem[count-1];
                count  <= count - 1;
            end
        end
    end

    assign stk_data_out = dout_q;
    assign stk_empty    = empty_q && !force_nonempty;
    assign stk_full     = full_q;

    int         cyc = 0;
    int         push_cnt = 0, pop_cnt = 0, both_cnt = 0;
    logic [7:0] push_log[$];
    int         push_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (stk_push) begin
                push_cnt++;
                push_log.push_back(stk_data_in);
                push_cyc.push_back(cyc);
            end
            if (stk_pop) pop_cnt++;
            if (stk_push && stk_pop) both_cnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind: 1 = done, 2 = ovf_err, 3 = unf_err
    typedef struct {
        logic        call;
        logic        ret;
        logic [15:0] addr;
        int          kind;
        int          lat;
        logic [15:0] ret_out;
        logic [5:0]  depth;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic r, input logic [15:0] a,
                                input int k, input int l, input logic [15:0] ro,
                                input logic [5:0] d);
        vec_t v;
        v.call = c; v.ret = r; v.addr = a; v.kind = k; v.lat = l;
        v.ret_out = ro; v.depth = d;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int   lat;
        int   p0, q0, obs;
        logic b0;
        p0 = push_cnt;
        q0 = pop_cnt;
        call_req = v.call; ret_req = v.ret; ret_addr_in = v.addr;
        @(posedge clk); #1;
        call_req = 1'b0; ret_req = 1'b0; ret_addr_in = 16'hDEAD;
        b0  = busy;
        lat = 0;
        while (!(done || ovf_err || unf_err) && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        obs = done ? 1 : ovf_err ? 2 : unf_err ? 3 : 0;
        chk({tag, " outcome"}, obs, v.kind);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " busy_after_accept"}, {31'b0, b0}, {31'b0, v.kind == 1});
        chk({tag, " busy_at_end"}, {31'b0, busy}, 32'd0);
        chk({tag, " depth"}, {26'b0, depth}, {26'b0, v.depth});
        chk({tag, " ret_addr_out"}, {16'b0, ret_addr_out}, {16'b0, v.ret_out});
        chk({tag, " push_count"}, push_cnt - p0, (v.kind == 1 && v.call) ? 2 : 0);
        chk({tag, " pop_count"}, pop_cnt - q0, (v.kind == 1 && !v.call) ? 2 : 0);
    endtask

    task automatic check_after_abort(input string tag);
        chk({tag, " busy"}, {31'b0, busy}, 32'd0);
        chk({tag, " depth"}, {26'b0, depth}, 32'd0);
        chk({tag, " done"}, {31'b0, done}, 32'd0);
        chk({tag, " ret_addr_out"}, {16'b0, ret_addr_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done_next"}, {31'b0, done}, 32'd0);
        chk({tag, " busy_next"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Expected sequence: CALL/RET, underflow, 15 nested CALLs, overflow, 15 RETs LIFO.
        vecs.push_back(mk(1, 0, 16'h1234, 1, 2, 16'h0000, 6'd2));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 3, 16'h1234, 6'd0));
        vecs.push_back(mk(0, 1, 16'h0000, 3, 0, 16'h1234, 6'd0));
        for (int i = 0; i < 15; i++)
            vecs.push_back(mk(1, 0, 16'h0100 + 16'(i), 1, 2, 16'h1234, 6'(2 * (i + 1))));
        vecs.push_back(mk(1, 0, 16'h0FFF, 2, 0, 16'h1234, 6'd30));
        for (int j = 0; j < 15; j++)
            vecs.push_back(mk(0, 1, 16'h0000, 1, 3, 16'h010E - 16'(j), 6'(28 - 2 * j)));
        vecs.push_back(mk(1, 1, 16'hBEEF, 1, 2, 16'h0100, 6'd2));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 3, 16'hBEEF, 6'd0));
        vecs.push_back(mk(0, 1, 16'h0000, 3, 0, 16'hBEEF, 6'd0));

        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0; ret_addr_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset ovf_err", {31'b0, ovf_err}, 32'd0);
        chk("reset unf_err", {31'b0, unf_err}, 32'd0);
        chk("reset depth", {26'b0, depth}, 32'd0);
        chk("reset ret_addr_out", {16'b0, ret_addr_out}, 32'd0);
        chk("reset stk_push", {31'b0, stk_push}, 32'd0);
        chk("reset stk_pop", {31'b0, stk_pop}, 32'd0);
        chk("reset stk_data_in", {24'b0, stk_data_in}, 32'd0);
        chk("reset sync_err", {31'b0, sync_err}, 32'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            run_op(vecs[k], $sformatf("vec%0d", k));
            if (k == 0) begin
                chk("call push0 byte", {24'b0, push_log[0]}, 32'h34);
                chk("call push1 byte", {24'b0, push_log[1]}, 32'h12);
                chk("call push consecutive", push_cyc[1] - push_cyc[0], 1);
            end
        end

        // Reset while in PUSH_HI.
        run_op(mk(1, 0, 16'h5555, 1, 2, 16'hBEEF, 6'd2), "preA");
        call_req = 1'b1; ret_addr_in = 16'hAAAA;
        @(posedge clk); #1;
        call_req = 1'b0;
        @(posedge clk); #1;
        chk("abortA in push_hi", {31'b0, stk_push}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_after_abort("abortA");
        run_op(mk(1, 0, 16'h4321, 1, 2, 16'h0000, 6'd2), "postA_call");
        run_op(mk(0, 1, 16'h0000, 1, 3, 16'h4321, 6'd0), "postA_ret");

        // Reset while in POP_LO.
        run_op(mk(1, 0, 16'h7777, 1, 2, 16'h4321, 6'd2), "preB");
        ret_req = 1'b1;
        @(posedge clk); #1;
        ret_req = 1'b0;
        @(posedge clk); #1;
        chk("abortB in pop_lo", {31'b0, stk_pop}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_after_abort("abortB");
        run_op(mk(1, 0, 16'h2468, 1, 2, 16'h0000, 6'd2), "postB_call");
        run_op(mk(0, 1, 16'h0000, 1, 3, 16'h2468, 6'd0), "postB_ret");

        // Flag consistency: stack claims non-empty while depth is 0.
        repeat (2) @(posedge clk);
        #1;
        chk("sync_err before", {31'b0, sync_err}, 32'd0);
        force_nonempty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        force_nonempty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sync_err sticky", {31'b0, sync_err}, {31'b0, CHK});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("sync_err cleared", {31'b0, sync_err}, 32'd0);

        chk("push_pop_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
